// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: issues single-beat imem reads at current_pc and
// buffers PC-tagged instructions in a small FIFO feeding decode.
module ifetch_unit #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] current_pc,
  output logic              enable_pc,
  input  logic              do_flush_REG1,
  input  logic              do_hazard,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic              fetch_error
);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  state_t            state, state_nxt;
  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [WAIT_W-1:0] wait_cnt;
  logic              flush_q;
  logic              issue, push, pop, pulse;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    state_nxt = state;
    issue     = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE: begin
        // count only holds buffered entries here; nothing is outstanding in IDLE
        if (!do_hazard && !do_flush_REG1 && !enable_pc && count < CNT_W'(DEPTH)) begin
          issue     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        push = imem_ack && !do_flush_REG1;
        if (imem_ack)           state_nxt = IDLE;
        else if (do_flush_REG1) state_nxt = DROP;
      end
      DROP: begin
        if (imem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign imem_req   = (state != IDLE);
  assign pop        = inst_valid && inst_ready;
  assign pulse      = push || (do_flush_REG1 && !flush_q);
  assign inst_valid = (count != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      enable_pc   <= 1'b0;
      flush_q     <= 1'b0;
      imem_addr   <= '0;
      wait_cnt    <= '0;
      fetch_error <= 1'b0;
    end else begin
      enable_pc <= pulse;
      flush_q   <= do_flush_REG1;
      if (issue) imem_addr <= current_pc;
      if (imem_req && imem_ack) begin
        wait_cnt <= '0;
      end else if (imem_req && wait_cnt != WAIT_W'(MAX_WAIT)) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
        if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) fetch_error <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (do_flush_REG1) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; the head is gated by inst_valid so stale entries never show.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= '{data: imem_rdata, pc: imem_addr};
  end

  assign inst    = inst_valid ? mem[rd_ptr].data : '0;
  assign inst_pc = inst_valid ? mem[rd_ptr].pc   : '0;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_ifetch_unit;
  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 32;
  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 15;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [ADDR_W-1:0] current_pc = '0;
  logic              enable_pc;
  logic              do_flush_REG1 = 1'b0;
  logic              do_hazard = 1'b0;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack = 1'b0;
  logic [DATA_W-1:0] imem_rdata = '0;
  logic              inst_valid;
  logic [DATA_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready = 1'b1;
  logic              fetch_error;

  always #5 clock = ~clock;

  ifetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clock(clock), .reset(reset), .current_pc(current_pc), .enable_pc(enable_pc),
    .do_flush_REG1(do_flush_REG1), .do_hazard(do_hazard), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .fetch_error(fetch_error)
  );

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] a;
  } ent_t;

  // reference model: a request is either absent, kept or to be discarded
  ent_t              q[$];
  bit                m_busy, m_keep, m_en, m_fprev, m_err;
  logic [ADDR_W-1:0] m_addr;
  int                m_wait;

  int errors = 0;
  int checks = 0;

  // environment: memory with programmable latency and a simple PC generator
  int                lat = 0;
  int                age = 0;
  bit                withhold = 0;
  bit                prev_req = 0;
  int                req_rises = 0;
  int                en_pulses = 0;
  logic [ADDR_W-1:0] last_issue = '0;
  logic [ADDR_W-1:0] redir_target = '0;
  bit                redir_pend = 0;
  logic [ADDR_W-1:0] popped[$];

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return 32'hC0DE_0000 ^ (DATA_W'(a) * 32'h0001_0003);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_busy = 0; m_keep = 0; m_en = 0; m_fprev = 0; m_err = 0;
    m_addr = '0; m_wait = 0;
  endtask

  task automatic env_reset();
    age = 0; prev_req = 0; current_pc = '0; redir_pend = 0;
  endtask

  task automatic model_step();
    int old_size;
    bit ack_ok, keep_resp, start, new_en;
    if (!reset) begin
      model_reset();
      return;
    end
    old_size  = q.size();
    ack_ok    = m_busy && imem_ack;
    keep_resp = ack_ok && m_keep && !do_flush_REG1;
    start     = !m_busy && !do_hazard && !do_flush_REG1 && !m_en && old_size < DEPTH;
    new_en    = (do_flush_REG1 && !m_fprev) || keep_resp;
    if (do_flush_REG1) q.delete();
    else begin
      if (old_size > 0 && inst_ready) void'(q.pop_front());
      if (keep_resp) q.push_back('{d: imem_rdata, a: m_addr});
    end
    if (m_busy && !imem_ack) begin
      if (m_wait < MAX_WAIT) m_wait++;
      if (m_wait == MAX_WAIT) m_err = 1;
    end else if (m_busy) begin
      m_wait = 0;
    end
    if (ack_ok) m_busy = 0;
    else if (m_busy && do_flush_REG1) m_keep = 0;
    else if (start) begin
      m_busy = 1; m_keep = 1; m_addr = current_pc;
    end
    m_en    = new_en;
    m_fprev = do_flush_REG1;
  endtask

  task automatic compare();
    logic [DATA_W-1:0] e_inst;
    logic [ADDR_W-1:0] e_pc;
    e_inst = '0;
    e_pc   = '0;
    if (q.size() > 0) begin
      e_inst = q[0].d;
      e_pc   = q[0].a;
    end
    check("enable_pc",   enable_pc,   m_en);
    check("imem_req",    imem_req,    m_busy);
    check("imem_addr",   imem_addr,   m_addr);
    check("inst_valid",  inst_valid,  q.size() > 0);
    check("inst",        inst,        e_inst);
    check("inst_pc",     inst_pc,     e_pc);
    check("fetch_error", fetch_error, m_err);
  endtask

  // one clock: compare and drive at negedge, advance model just after posedge
  task automatic cycle();
    bit s_req, s_en;
    @(negedge clock);
    compare();
    s_req = imem_req;
    s_en  = enable_pc;
    imem_ack   = s_req && !withhold && (age == lat);
    imem_rdata = imem_ack ? mem_word(imem_addr) : DATA_W'($urandom);
    if (s_req && !prev_req) begin
      req_rises++;
      last_issue = imem_addr;
    end
    prev_req = s_req;
    if (s_en) en_pulses++;
    if (inst_valid && inst_ready) popped.push_back(inst_pc);
    @(posedge clock);
    #1;
    model_step();
    if (!reset) env_reset();
    else begin
      age = (s_req && !imem_ack) ? age + 1 : 0;
      if (s_en) begin
        current_pc = redir_pend ? redir_target : current_pc + ADDR_W'(4);
        redir_pend = 0;
      end
    end
  endtask

  task automatic do_reset();
    do_flush_REG1 = 0; do_hazard = 0; withhold = 0; lat = 0;
    reset = 0;
    #1;
    model_reset();
    env_reset();
    cycle();
    cycle();
    reset = 1;
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 30 && !imem_req; i++) cycle();
    check(name, imem_req, 1'b1);
  endtask

  task automatic flush_now(input logic [ADDR_W-1:0] target);
    do_flush_REG1 = 1;
    redir_target  = target;
    redir_pend    = 1;
  endtask

  initial begin
    int n0;
    model_reset();
    #1;
    check("rst_imem_req",    imem_req,    1'b0);
    check("rst_enable_pc",   enable_pc,   1'b0);
    check("rst_imem_addr",   imem_addr,   '0);
    check("rst_inst_valid",  inst_valid,  1'b0);
    check("rst_inst",        inst,        '0);
    check("rst_fetch_error", fetch_error, 1'b0);
    cycle();
    cycle();
    reset = 1;

    // basic zero-wait fetch stream
    inst_ready = 1;
    popped.delete();
    repeat (20) cycle();
    check("basic_count", popped.size() >= 3, 1'b1);
    for (int i = 0; i < 3; i++)
      if (i < popped.size()) check($sformatf("basic_pc%0d", i), popped[i], 64'(4 * i));

    // backpressure: two fetches fill the FIFO, head held
    do_reset();
    inst_ready = 0;
    req_rises  = 0;
    repeat (20) cycle();
    check("bp_req_count", req_rises, 2);
    check("bp_valid",     inst_valid, 1'b1);
    check("bp_head_pc",   inst_pc,    '0);
    check("bp_head_inst", inst,       mem_word('0));
    inst_ready = 1;
    req_rises  = 0;
    for (int i = 0; i < 20 && req_rises == 0; i++) cycle();
    check("bp_resume_addr", last_issue, 10'h008);

    // flush while a latency-3 request is in flight
    do_reset();
    inst_ready = 1;
    lat = 3;
    wait_req("ff_req");
    cycle();
    n0 = popped.size();
    en_pulses = 0;
    flush_now(10'h040);
    cycle();
    do_flush_REG1 = 0;
    check("ff_valid", inst_valid, 1'b0);
    req_rises = 0;
    for (int i = 0; i < 20 && req_rises == 0; i++) cycle();
    check("ff_new_addr", last_issue, 10'h040);
    check("ff_en_pulses", en_pulses, 1);
    check("ff_no_push", popped.size() - n0, 0);

    // flush on the same edge as the ack
    do_reset();
    lat = 2;
    for (int i = 0; i < 30 && !(imem_req && age == lat); i++) cycle();
    check("fa_ready", imem_req && age == lat, 1'b1);
    en_pulses = 0;
    flush_now(10'h100);
    cycle();
    do_flush_REG1 = 0;
    check("fa_valid0", inst_valid, 1'b0);
    cycle();
    check("fa_valid1", inst_valid, 1'b0);
    cycle();
    check("fa_en_pulses", en_pulses, 1);

    // hazard while idle, then hazard over an outstanding request
    do_reset();
    do_hazard = 1;
    req_rises = 0;
    repeat (5) cycle();
    check("hz_no_req", req_rises, 0);
    do_hazard = 0;
    lat = 3;
    wait_req("hz_req");
    do_hazard = 1;
    en_pulses = 0;
    n0 = popped.size();
    repeat (8) cycle();
    check("hz_en_pulses", en_pulses, 1);
    check("hz_completed", popped.size() - n0, 1);
    check("hz_idle", imem_req, 1'b0);
    do_hazard = 0;

    // randomized traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      inst_ready    = ($urandom_range(0, 9) < 7);
      do_hazard     = ($urandom_range(0, 9) == 0);
      do_flush_REG1 = 0;
      if ($urandom_range(0, 19) == 0) flush_now(ADDR_W'($urandom_range(0, 255) * 4));
      if (!imem_req) lat = $urandom_range(0, 3);
      cycle();
    end

    // ack timeout, then asynchronous reset mid-wait
    do_flush_REG1 = 0; do_hazard = 0; inst_ready = 1;
    withhold = 1;
    wait_req("to_req");
    repeat (20) cycle();
    check("to_error", fetch_error, 1'b1);
    repeat (3) cycle();
    check("to_sticky",  fetch_error, 1'b1);
    check("to_pending", imem_req,    1'b1);
    @(negedge clock);
    #2;
    reset = 0;
    #1;
    check("ar_imem_req",    imem_req,    1'b0);
    check("ar_fetch_error", fetch_error, 1'b0);
    model_reset();
    env_reset();
    withhold = 0;
    cycle();
    cycle();
    reset = 1;
    repeat (10) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
